// File: rtl/osd_textwriter_if.sv
`default_nettype none
// ============================================================================
// Module      : osd_textwriter_if
// Description : Bundles the OSD command handshake and the text screen buffer
//               host port into one interface.
//               Command side : cmd_valid, cmd_op[2:0], cmd_data[7:0], cmd_ready
//               Buffer side  : address[AW-1:0], data[7:0], wren, q[7:0]
//               Status       : cursor[AW-1:0]
//               The master modport belongs to the host and the buffer RAM.
//               The slave modport belongs to the writer.
// Revision    : 1.0 - initial release
// ============================================================================
interface osd_textwriter_if #(
  parameter int AW = 8
);
  logic          cmd_valid;
  logic [2:0]    cmd_op;
  logic [7:0]    cmd_data;
  logic          cmd_ready;
  logic [AW-1:0] address;
  logic [7:0]    data;
  logic          wren;
  logic [7:0]    q;
  logic [AW-1:0] cursor;

  modport master (
    output cmd_valid, cmd_op, cmd_data, q,
    input  cmd_ready, address, data, wren, cursor
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, q,
    output cmd_ready, address, data, wren, cursor
  );
endinterface
`default_nettype wire

// File: rtl/osd_textwriter.sv
`default_nettype none
// ============================================================================
// Module      : osd_textwriter
// Description : Turns byte-level OSD print/cursor commands into write cycles
//               on the host port of a COLS x ROWS text screen buffer. Keeps the
//               cursor and invert attribute, handles CR/LF/BS, clears the
//               screen, and scrolls the window up one row at end of screen.
// Ports       : clk      - system clock, rising edge
//               reset_n  - synchronous active-low reset
//               bus      - osd_textwriter_if.slave (command handshake,
//                          buffer address/data/wren/q, cursor status)
// Revision    : 1.0 - initial release
// ============================================================================
module osd_textwriter #(
  parameter int         COLS       = 32,
  parameter int         ROWS       = 8,
  parameter int         AW         = 8,
  parameter logic [7:0] BLANK      = 8'h20,
  parameter int         AUTOSCROLL = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  osd_textwriter_if.slave    bus
);

  localparam logic [2:0] c_OP_PUTC    = 3'd0;
  localparam logic [2:0] c_OP_GOTO    = 3'd1;
  localparam logic [2:0] c_OP_CLEAR   = 3'd2;
  localparam logic [2:0] c_OP_HEX     = 3'd3;
  localparam logic [2:0] c_OP_SETATTR = 3'd4;

  localparam logic [AW-1:0] c_ONE       = AW'(1);
  localparam logic [AW-1:0] c_LAST      = '1;
  localparam logic [AW-1:0] c_COLS_A    = AW'(COLS);
  localparam logic [AW-1:0] c_COL_MASK  = AW'(COLS - 1);
  localparam logic [AW-1:0] c_LASTROW   = AW'((ROWS - 1) * COLS);
  localparam logic [AW-1:0] c_SCRL_LAST = AW'((ROWS - 1) * COLS - 1);
  localparam logic [7:0]    c_BLANK_W   = {1'b0, BLANK[6:0]};

  typedef enum logic [2:0] {
    S_IDLE, S_PUTC, S_HEXLO, S_CLEAR,
    S_SCRL_RD, S_SCRL_WAIT, S_SCRL_WR, S_SCRL_FILL
  } state_t;

  state_t        r_state;
  logic [2:0]    r_op;
  logic [7:0]    r_data;
  logic          r_inv;
  logic          r_hex_pend;   // low HEX digit still owed after a scroll
  logic [AW-1:0] r_cursor;
  logic [AW-1:0] r_address;
  logic [AW-1:0] r_idx;        // destination cell of the scroll copy
  logic [7:0]    r_wdata;
  logic          r_wren;

  logic          w_eos;
  logic [AW-1:0] w_next;
  logic [AW-1:0] w_row_start;
  logic          w_in_last_row;
  logic          w_is_ctrl;
  logic [6:0]    w_hex_hi;
  logic [6:0]    w_hex_lo;

  function automatic logic [6:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? {3'b011, n} : (7'h37 + {3'b000, n});
  endfunction

  assign w_row_start   = r_cursor & ~c_COL_MASK;
  assign w_in_last_row = (r_cursor >= c_LASTROW);
  assign w_is_ctrl     = (bus.cmd_data == 8'h0A) || (bus.cmd_data == 8'h0D) ||
                         (bus.cmd_data == 8'h08);
  assign w_hex_hi      = hex_ascii(bus.cmd_data[7:4]);
  assign w_hex_lo      = hex_ascii(r_data[3:0]);

  // Cursor outcome of the command held in r_op/r_data; w_eos flags the two
  // cases that run off the end of the screen.
  always_comb begin
    w_eos  = 1'b0;
    w_next = r_cursor;
    case (r_op)
      c_OP_PUTC: begin
        case (r_data)
          8'h0A: begin
            if (w_in_last_row) w_eos = 1'b1;
            else               w_next = w_row_start + c_COLS_A;
          end
          8'h0D: w_next = w_row_start;
          8'h08: w_next = (r_cursor == '0) ? '0 : (r_cursor - c_ONE);
          default: begin
            if (r_cursor == c_LAST) w_eos = 1'b1;
            else                    w_next = r_cursor + c_ONE;
          end
        endcase
      end
      c_OP_GOTO: w_next = AW'(r_data);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_op       <= 3'd0;
      r_data     <= 8'h00;
      r_inv      <= 1'b0;
      r_hex_pend <= 1'b0;
      r_cursor   <= '0;
      r_address  <= '0;
      r_idx      <= '0;
      r_wdata    <= 8'h00;
      r_wren     <= 1'b0;
    end else begin
      r_wren <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            r_op   <= bus.cmd_op;
            r_data <= bus.cmd_data;
            case (bus.cmd_op)
              c_OP_PUTC: begin
                r_state <= S_PUTC;
                if (!w_is_ctrl) begin
                  r_wren    <= 1'b1;
                  r_address <= r_cursor;
                  r_wdata   <= {r_inv, bus.cmd_data[6:0]};
                end
              end
              c_OP_HEX: begin
                r_state   <= S_HEXLO;
                r_wren    <= 1'b1;
                r_address <= r_cursor;
                r_wdata   <= {r_inv, w_hex_hi};
              end
              c_OP_CLEAR: begin
                r_state   <= S_CLEAR;
                r_wren    <= 1'b1;
                r_address <= '0;
                r_wdata   <= c_BLANK_W;
              end
              default: r_state <= S_PUTC;
            endcase
          end
        end

        // Finishes a single-cell command: cursor move, attribute, or scroll.
        S_PUTC: begin
          r_state <= S_IDLE;
          if (r_op == c_OP_SETATTR) r_inv <= r_data[0];
          if (w_eos) begin
            if (AUTOSCROLL != 0) begin
              r_state   <= S_SCRL_RD;
              r_idx     <= '0;
              r_address <= c_COLS_A;
            end else begin
              r_cursor <= '0;
            end
          end else begin
            r_cursor <= w_next;
          end
        end

        // High digit is written; the low digit becomes an ordinary PUTC.
        S_HEXLO: begin
          r_op   <= c_OP_PUTC;
          r_data <= {1'b0, w_hex_lo};
          if ((r_cursor == c_LAST) && (AUTOSCROLL != 0)) begin
            r_hex_pend <= 1'b1;
            r_state    <= S_SCRL_RD;
            r_idx      <= '0;
            r_address  <= c_COLS_A;
          end else begin
            r_cursor  <= r_cursor + c_ONE;
            r_wren    <= 1'b1;
            r_address <= r_cursor + c_ONE;
            r_wdata   <= {r_inv, w_hex_lo};
            r_state   <= S_PUTC;
          end
        end

        S_CLEAR: begin
          if (r_address == c_LAST) begin
            r_cursor <= '0;
            r_inv    <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            r_address <= r_address + c_ONE;
            r_wren    <= 1'b1;
          end
        end

        S_SCRL_RD: r_state <= S_SCRL_WAIT;

        // q now holds the cell one row below r_idx.
        S_SCRL_WAIT: begin
          r_address <= r_idx;
          r_wdata   <= bus.q;
          r_wren    <= 1'b1;
          r_state   <= S_SCRL_WR;
        end

        S_SCRL_WR: begin
          if (r_idx == c_SCRL_LAST) begin
            r_state   <= S_SCRL_FILL;
            r_address <= c_LASTROW;
            r_wdata   <= c_BLANK_W;
            r_wren    <= 1'b1;
          end else begin
            r_idx     <= r_idx + c_ONE;
            r_address <= r_idx + c_ONE + c_COLS_A;
            r_state   <= S_SCRL_RD;
          end
        end

        S_SCRL_FILL: begin
          if (r_address == c_LAST) begin
            r_cursor <= c_LASTROW;
            if (r_hex_pend) begin
              r_hex_pend <= 1'b0;
              r_wren     <= 1'b1;
              r_address  <= c_LASTROW;
              r_wdata    <= {r_inv, r_data[6:0]};
              r_state    <= S_PUTC;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_address <= r_address + c_ONE;
            r_wren    <= 1'b1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = (r_state == S_IDLE);
  assign bus.address   = r_address;
  assign bus.data      = r_wdata;
  assign bus.wren      = r_wren;
  assign bus.cursor    = r_cursor;

endmodule
`default_nettype wire

// File: tb/tb_osd_textwriter.sv
`default_nettype none
// ============================================================================
// Module      : tb_osd_textwriter
// Description : Self-checking bench for osd_textwriter. Models the 256-byte
//               screen RAM (registered read), logs every write, and compares
//               cursor, write traffic and busy time against hand-computed
//               values from a vector table and a few multi-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_osd_textwriter;

  localparam logic [2:0] OP_PUTC = 3'd0, OP_GOTO = 3'd1, OP_CLEAR = 3'd2,
                         OP_HEX = 3'd3, OP_SETATTR = 3'd4, OP_NOP = 3'd5;

  typedef struct {
    logic [2:0] op;
    logic [7:0] d;
    logic [7:0] cur;
    int         nwr;
    int         edges;
    logic [7:0] a0, d0, a1, d1;
  } vec_t;

  logic clk;
  logic reset_n;

  osd_textwriter_if #(.AW(8)) bus ();

  osd_textwriter #(
    .COLS(32), .ROWS(8), .AW(8), .BLANK(8'h20), .AUTOSCROLL(1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  logic [7:0] mem [256];
  logic [7:0] pre [256];
  logic [7:0] wa  [1024];
  logic [7:0] wd  [1024];
  int nwr;
  int tests;
  int fails;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Screen RAM model: read data appears on the edge after the address.
  always @(posedge clk) begin
    bus.q <= mem[bus.address];
    if (bus.wren === 1'b1) begin
      mem[bus.address] = bus.data;
      if (nwr < 1024) begin
        wa[nwr] = bus.address;
        wd[nwr] = bus.data;
      end
      nwr = nwr + 1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [7:0] d,
                              input logic [7:0] cur, input int n, input int e,
                              input logic [7:0] a0, input logic [7:0] d0,
                              input logic [7:0] a1, input logic [7:0] d1);
    vec_t v;
    v.op = op; v.d = d; v.cur = cur; v.nwr = n; v.edges = e;
    v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1;
    return v;
  endfunction

  // Called on a falling edge. edges = rising edges from accept until ready.
  task automatic do_cmd(input logic [2:0] op, input logic [7:0] d, output int edges);
    int guard;
    guard = 0;
    while (!bus.cmd_ready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    nwr = 0;
    bus.cmd_op    = op;
    bus.cmd_data  = d;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_NOP;
    edges = 1;
    while (!bus.cmd_ready && edges < 2000) begin
      @(negedge clk);
      edges++;
    end
  endtask

  initial begin
    vec_t vt[$];
    int   e;
    int   bad;
    logic [7:0] x;

    tests = 0;
    fails = 0;
    nwr   = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    reset_n       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_NOP;
    bus.cmd_data  = 8'h00;
    repeat (3) @(negedge clk);

    chk("rst_ready",   bus.cmd_ready, 1);
    chk("rst_wren",    bus.wren, 0);
    chk("rst_address", bus.address, 0);
    chk("rst_data",    bus.data, 0);
    chk("rst_cursor",  bus.cursor, 0);
    reset_n = 1'b1;
    @(negedge clk);

    //              op          data   cur    nwr  edges a0     d0     a1     d1
    vt.push_back(mk(OP_PUTC,    8'h41, 8'h01, 1,   2,    8'h00, 8'h41, 8'h00, 8'h00));
    vt.push_back(mk(OP_SETATTR, 8'h01, 8'h01, 0,   2,    8'h00, 8'h00, 8'h00, 8'h00));
    vt.push_back(mk(OP_GOTO,    8'h1F, 8'h1F, 0,   2,    8'h00, 8'h00, 8'h00, 8'h00));
    vt.push_back(mk(OP_HEX,     8'hA5, 8'h21, 2,   3,    8'h1F, 8'hC1, 8'h20, 8'hB5));
    vt.push_back(mk(OP_SETATTR, 8'h00, 8'h21, 0,   2,    8'h00, 8'h00, 8'h00, 8'h00));
    vt.push_back(mk(OP_NOP,     8'h77, 8'h21, 0,   2,    8'h00, 8'h00, 8'h00, 8'h00));
    vt.push_back(mk(OP_GOTO,    8'h25, 8'h25, 0,   2,    8'h00, 8'h00, 8'h00, 8'h00));
    vt.push_back(mk(OP_PUTC,    8'h0D, 8'h20, 0,   2,    8'h00, 8'h00, 8'h00, 8'h00));
    vt.push_back(mk(OP_PUTC,    8'h0A, 8'h40, 0,   2,    8'h00, 8'h00, 8'h00, 8'h00));
    vt.push_back(mk(OP_PUTC,    8'h08, 8'h3F, 0,   2,    8'h00, 8'h00, 8'h00, 8'h00));
    vt.push_back(mk(OP_GOTO,    8'h00, 8'h00, 0,   2,    8'h00, 8'h00, 8'h00, 8'h00));
    vt.push_back(mk(OP_PUTC,    8'h08, 8'h00, 0,   2,    8'h00, 8'h00, 8'h00, 8'h00));
    vt.push_back(mk(OP_HEX,     8'h3C, 8'h02, 2,   3,    8'h00, 8'h33, 8'h01, 8'h43));
    vt.push_back(mk(OP_GOTO,    8'hFE, 8'hFE, 0,   2,    8'h00, 8'h00, 8'h00, 8'h00));
    vt.push_back(mk(OP_PUTC,    8'h0D, 8'hE0, 0,   2,    8'h00, 8'h00, 8'h00, 8'h00));
    vt.push_back(mk(OP_GOTO,    8'h5F, 8'h5F, 0,   2,    8'h00, 8'h00, 8'h00, 8'h00));
    vt.push_back(mk(OP_PUTC,    8'h0A, 8'h60, 0,   2,    8'h00, 8'h00, 8'h00, 8'h00));
    vt.push_back(mk(OP_PUTC,    8'hC1, 8'h61, 1,   2,    8'h60, 8'h41, 8'h00, 8'h00));
    vt.push_back(mk(OP_GOTO,    8'hE5, 8'hE5, 0,   2,    8'h00, 8'h00, 8'h00, 8'h00));
    vt.push_back(mk(OP_PUTC,    8'h0A, 8'hE0, 256, 706,  8'h00, 8'h00, 8'h00, 8'h00));
    vt.push_back(mk(3'd7,       8'h12, 8'hE0, 0,   2,    8'h00, 8'h00, 8'h00, 8'h00));

    foreach (vt[i]) begin
      do_cmd(vt[i].op, vt[i].d, e);
      chk($sformatf("v%0d_cursor", i), int'(bus.cursor), int'(vt[i].cur));
      chk($sformatf("v%0d_nwr", i), nwr, vt[i].nwr);
      chk($sformatf("v%0d_edges", i), e, vt[i].edges);
      if (vt[i].nwr >= 1 && vt[i].nwr <= 2) begin
        chk($sformatf("v%0d_addr0", i), int'(wa[0]), int'(vt[i].a0));
        chk($sformatf("v%0d_data0", i), int'(wd[0]), int'(vt[i].d0));
      end
      if (vt[i].nwr == 2) begin
        chk($sformatf("v%0d_addr1", i), int'(wa[1]), int'(vt[i].a1));
        chk($sformatf("v%0d_data1", i), int'(wd[1]), int'(vt[i].d1));
      end
    end

    // CLEAR with a PUTC queued behind it on a held cmd_valid.
    do_cmd(OP_SETATTR, 8'h01, e);
    do_cmd(OP_GOTO, 8'h50, e);
    nwr = 0;
    bus.cmd_op = OP_CLEAR; bus.cmd_data = 8'h00; bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_op = OP_PUTC; bus.cmd_data = 8'h41;
    e = 1;
    while (!bus.cmd_ready && e < 2000) begin
      @(negedge clk);
      e++;
    end
    chk("clr_edges", e, 257);
    chk("clr_nwr", nwr, 256);
    bad = 0;
    for (int i = 0; i < 256; i++)
      if (wa[i] != 8'(i) || wd[i] != 8'h20) bad++;
    chk("clr_seq_bad", bad, 0);
    chk("clr_cursor", int'(bus.cursor), 0);
    @(negedge clk);
    bus.cmd_valid = 1'b0; bus.cmd_op = OP_NOP;
    e = 1;
    while (!bus.cmd_ready && e < 2000) begin
      @(negedge clk);
      e++;
    end
    chk("clr_putc_nwr", nwr, 257);
    chk("clr_putc_addr", int'(wa[256]), 0);
    chk("clr_putc_data", int'(wd[256]), 8'h41);
    chk("clr_putc_cursor", int'(bus.cursor), 1);

    // Scroll from a printable at the last cell.
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    do_cmd(OP_GOTO, 8'hFF, e);
    do_cmd(OP_PUTC, 8'h58, e);
    chk("scr_edges", e, 706);
    chk("scr_nwr", nwr, 257);
    chk("scr_cursor", int'(bus.cursor), 8'hE0);
    bad = 0;
    for (int i = 0; i < 224; i++) begin
      x = (i + 32 == 255) ? 8'h58 : 8'(i + 32);
      if (mem[i] != x) bad++;
    end
    for (int i = 224; i < 256; i++) if (mem[i] != 8'h20) bad++;
    chk("scr_cells_bad", bad, 0);
    chk("scr_cell_df", int'(mem[8'hDF]), 8'h58);
    chk("scr_cell_00", int'(mem[0]), 8'h20);

    // HEX whose first digit lands on the last cell: scroll between digits.
    do_cmd(OP_SETATTR, 8'h01, e);
    do_cmd(OP_GOTO, 8'hFF, e);
    for (int i = 0; i < 256; i++) pre[i] = mem[i];
    pre[255] = 8'hB7;
    do_cmd(OP_HEX, 8'h7E, e);
    chk("hexscr_edges", e, 707);
    chk("hexscr_nwr", nwr, 258);
    chk("hexscr_cursor", int'(bus.cursor), 8'hE1);
    bad = 0;
    for (int i = 0; i < 224; i++) if (mem[i] != pre[i + 32]) bad++;
    for (int i = 224; i < 256; i++) begin
      x = (i == 224) ? 8'hC5 : 8'h20;
      if (mem[i] != x) bad++;
    end
    chk("hexscr_cells_bad", bad, 0);
    chk("hexscr_cell_df", int'(mem[8'hDF]), 8'hB7);
    chk("hexscr_cell_e0", int'(mem[8'hE0]), 8'hC5);

    // Reset in the middle of CLEAR.
    do_cmd(OP_GOTO, 8'h33, e);
    for (int i = 0; i < 256; i++) mem[i] = 8'hEE;
    nwr = 0;
    bus.cmd_op = OP_CLEAR; bus.cmd_data = 8'h00; bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0; bus.cmd_op = OP_NOP;
    e = 0;
    while (!(bus.wren === 1'b1 && bus.address == 8'd99) && e < 400) begin
      @(negedge clk);
      e++;
    end
    chk("rstclr_reach99", (bus.wren === 1'b1 && bus.address == 8'd99) ? 1 : 0, 1);
    reset_n = 1'b0;
    @(negedge clk);
    chk("rstclr_wren", bus.wren, 0);
    chk("rstclr_cursor", int'(bus.cursor), 0);
    chk("rstclr_ready", bus.cmd_ready, 1);
    chk("rstclr_address", int'(bus.address), 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rstclr_nwr", nwr, 100);
    chk("rstclr_cell99", int'(mem[99]), 8'h20);
    bad = 0;
    for (int i = 100; i < 256; i++) if (mem[i] != 8'hEE) bad++;
    chk("rstclr_untouched_bad", bad, 0);
    do_cmd(OP_PUTC, 8'h41, e);
    chk("rstclr_putc_addr", int'(wa[0]), 0);
    chk("rstclr_putc_data", int'(wd[0]), 8'h41);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
